// File: rtl/hp_manager.sv
// Round controller and health bookkeeping for both players: accepts hits,
// drains pending damage one HP per frame, detects KO and sequences the round.
module hp_manager #(
  parameter int TOTAL_HP       = 20,
  parameter int HP_W           = 19,
  parameter int HIT_COOLDOWN   = 30,
  parameter int KO_HOLD_FRAMES = 120
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic            round_start,
  input  logic            hit1,
  input  logic [4:0]      dmg1,
  input  logic            hit2,
  input  logic [4:0]      dmg2,
  output logic [HP_W-1:0] hp1,
  output logic [HP_W-1:0] hp2,
  output logic            exist_hp,
  output logic            ko1,
  output logic            ko2,
  output logic            round_over
);

  localparam int PD_W = $clog2(TOTAL_HP + 1);
  localparam int SM_W = PD_W + 2;
  localparam int CD_W = $clog2(HIT_COOLDOWN + 1);
  localparam int KO_W = $clog2(KO_HOLD_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_FIGHT, S_KO, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [KO_W-1:0]   ko_cnt_reg, ko_cnt_next;
  logic              ko1_reg, ko1_next, ko2_reg, ko2_next;
  logic              exist_reg, round_over_reg;
  logic              frame_clk_d_reg;
  logic              frame_tick;
  logic              draining;
  logic [1:0]        hit_vec;
  logic [1:0][4:0]   dmg_vec;

  assign frame_tick = frame_clk & ~frame_clk_d_reg;
  assign draining   = (state_reg == S_FIGHT) || (state_reg == S_KO);
  assign hit_vec    = {hit2, hit1};
  assign dmg_vec    = {dmg2, dmg1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [HP_W-1:0] hp_reg, hp_next;
      logic [PD_W-1:0] pend_reg, pend_next;
      logic [CD_W-1:0] cd_reg, cd_next;
      logic [SM_W-1:0] pend_sum;
      logic            accept, drain, hp_zero;

      always_comb begin
        accept   = (state_reg == S_FIGHT) && hit_vec[gi] && (dmg_vec[gi] != 5'd0) && (cd_reg == '0);
        drain    = draining && frame_tick && (pend_reg != '0) && (hp_reg != '0);
        hp_next  = hp_reg - HP_W'(drain);
        hp_zero  = (hp_next == '0);
        pend_sum = SM_W'(pend_reg) - SM_W'(drain) + (accept ? SM_W'(dmg_vec[gi]) : '0);
        pend_next = (pend_sum > SM_W'(TOTAL_HP)) ? PD_W'(TOTAL_HP) : pend_sum[PD_W-1:0];
        // Nothing left to drain once the player is down.
        if (hp_zero) pend_next = '0;
        cd_next = cd_reg;
        if (accept)
          cd_next = CD_W'(HIT_COOLDOWN);
        else if (frame_tick && (cd_reg != '0))
          cd_next = cd_reg - 1'b1;
      end

      always_ff @(posedge Clk) begin
        if (Reset || round_start) begin
          hp_reg   <= HP_W'(TOTAL_HP);
          pend_reg <= '0;
          cd_reg   <= '0;
        end else begin
          hp_reg   <= hp_next;
          pend_reg <= pend_next;
          cd_reg   <= cd_next;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    ko_cnt_next = ko_cnt_reg;
    ko1_next    = ko1_reg;
    ko2_next    = ko2_reg;
    if (round_start) begin
      state_next  = S_FIGHT;
      ko_cnt_next = '0;
      ko1_next    = 1'b0;
      ko2_next    = 1'b0;
    end else begin
      case (state_reg)
        S_FIGHT: begin
          if (g_player[0].hp_zero || g_player[1].hp_zero) begin
            state_next  = S_KO;
            ko1_next    = g_player[0].hp_zero;
            ko2_next    = g_player[1].hp_zero;
            ko_cnt_next = '0;
          end
        end
        S_KO: begin
          if (frame_tick) begin
            if (ko_cnt_reg == KO_W'(KO_HOLD_FRAMES - 1))
              state_next = S_DONE;
            else
              ko_cnt_next = ko_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      ko_cnt_reg      <= '0;
      ko1_reg         <= 1'b0;
      ko2_reg         <= 1'b0;
      exist_reg       <= 1'b0;
      round_over_reg  <= 1'b0;
      frame_clk_d_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ko_cnt_reg      <= ko_cnt_next;
      ko1_reg         <= ko1_next;
      ko2_reg         <= ko2_next;
      exist_reg       <= (state_next == S_FIGHT) || (state_next == S_KO);
      round_over_reg  <= (state_next == S_DONE);
      frame_clk_d_reg <= frame_clk;
    end
  end

  assign hp1        = g_player[0].hp_reg;
  assign hp2        = g_player[1].hp_reg;
  assign exist_hp   = exist_reg;
  assign ko1        = ko1_reg;
  assign ko2        = ko2_reg;
  assign round_over = round_over_reg;

endmodule
